// File: rtl/pchip_pktbuf_if.sv
// Bus bundle for the chip-path packet buffer: chip write side, readout side and status.
// Handshake: a chip word transfers on a clk_sys edge where chip_vld & chip_rdy; chip_vld
// with chip_rdy low drops the word. A read is accepted when pcbuf_rdreq & !pcbuf_empty,
// and pcbuf_qvld marks pcbuf_q in the following cycle.
interface pchip_pktbuf_if #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter int LW = 20
);
  logic [DW-1:0] chip_d;
  logic          chip_vld;
  logic          chip_rdy;
  logic [LW-1:0] chip_len;
  logic          mode;
  logic          clr;
  logic          pcbuf_rdreq;
  logic [DW-1:0] pcbuf_q;
  logic          pcbuf_qvld;
  logic          pcbuf_full;
  logic          pcbuf_empty;
  logic [AW:0]   pcbuf_usedw;
  logic          ovf_err;
  logic [1:0]    dbg_state;

  modport master (
    output chip_d, chip_vld, chip_len, mode, clr, pcbuf_rdreq,
    input  chip_rdy, pcbuf_q, pcbuf_qvld, pcbuf_full, pcbuf_empty, pcbuf_usedw,
           ovf_err, dbg_state
  );

  modport slave (
    input  chip_d, chip_vld, chip_len, mode, clr, pcbuf_rdreq,
    output chip_rdy, pcbuf_q, pcbuf_qvld, pcbuf_full, pcbuf_empty, pcbuf_usedw,
           ovf_err, dbg_state
  );
endinterface

// File: rtl/pchip_pktbuf.sv
// Frame buffer between the chip data path and the packet assembler: captures one frame
// into a dual-port RAM FIFO and drains it in store-and-forward or cut-through mode.
module pchip_pktbuf #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter int LW = 20
) (
  input  logic           clk_sys,
  input  logic           rst_n,
  pchip_pktbuf_if.slave  bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t        state_q;
  logic          chip_rdy_q;
  logic          full_q;
  logic [AW:0]   wr_cnt_q;
  logic [AW:0]   len_q;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   usedw_q, usedw_d;
  logic          qvld_q, qvld_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] q_q, q_d;

  logic          wr_en;
  logic          rd_en;
  logic          readable;
  logic [LW:0]   len_ext;
  logic [AW:0]   len_eff;

  // A zero or oversize length means "one full FIFO's worth", so a frame always fits.
  always_comb begin
    len_ext = {1'b0, bus.chip_len};
    if (bus.chip_len == '0 || len_ext > (LW+1)'(DEPTH)) begin
      len_eff = (AW+1)'(DEPTH);
    end else begin
      len_eff = bus.chip_len[AW:0];
    end
  end

  always_comb begin
    readable = (usedw_q != '0) && (bus.mode || (state_q == ST_HOLD));
    wr_en    = bus.chip_vld && chip_rdy_q && !bus.clr;
    rd_en    = bus.pcbuf_rdreq && readable && !bus.clr;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    qvld_d   = 1'b0;
    ovf_d    = ovf_q;
    q_d      = q_q;
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        q_d      = mem[rd_ptr_q];
      end
      qvld_d = rd_en;
      case ({wr_en, rd_en})
        2'b10:   usedw_d = usedw_q + 1'b1;
        2'b01:   usedw_d = usedw_q - 1'b1;
        default: usedw_d = usedw_q;
      endcase
      if (bus.chip_vld && !chip_rdy_q) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      qvld_q   <= 1'b0;
      ovf_q    <= 1'b0;
      q_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      qvld_q   <= qvld_d;
      ovf_q    <= ovf_d;
      q_q      <= q_d;
    end
  end

  // RAM array carries no reset so it maps onto block memory.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr_q] <= bus.chip_d;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      chip_rdy_q <= 1'b1;
      full_q     <= 1'b0;
      wr_cnt_q   <= '0;
      len_q      <= '0;
    end else if (bus.clr) begin
      state_q    <= ST_IDLE;
      chip_rdy_q <= 1'b1;
      full_q     <= 1'b0;
      wr_cnt_q   <= '0;
      len_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wr_en) begin
            len_q    <= len_eff;
            wr_cnt_q <= (AW+1)'(1);
            if (len_eff == (AW+1)'(1)) begin
              state_q    <= ST_HOLD;
              chip_rdy_q <= 1'b0;
              full_q     <= 1'b1;
            end else begin
              state_q <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (wr_en) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_cnt_q + 1'b1 == len_q) begin
              state_q    <= ST_HOLD;
              chip_rdy_q <= 1'b0;
              full_q     <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Leave only once the registered count shows the frame fully drained.
          if (usedw_q == '0) begin
            state_q    <= ST_IDLE;
            chip_rdy_q <= 1'b1;
            full_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          chip_rdy_q <= 1'b1;
          full_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.chip_rdy    = chip_rdy_q;
  assign bus.pcbuf_q     = q_q;
  assign bus.pcbuf_qvld  = qvld_q;
  assign bus.pcbuf_full  = full_q;
  assign bus.pcbuf_empty = !readable;
  assign bus.pcbuf_usedw = usedw_q;
  assign bus.ovf_err     = ovf_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: doc/pchip_pktbuf.md
Name: pchip_pktbuf

Overview:
- Parametrised successor to the chip-path packet buffer.
- Captures one frame of chip_len words from the chip path into an inferred dual-port RAM FIFO, then drains it to the packet/readout side.
- Adds a frame-level write FSM, a store-and-forward / cut-through mode, a one-cycle read-valid strobe, a sticky overflow flag, and a synchronous flush.
- Sits between the chip data path and the packet assembler, single clock domain clk_sys.

Parameters:
DW, 16, data word width
AW, 12, address width; FIFO depth DEPTH = 2^AW words
LW, 20, width of chip_len

Ports:
clk_sys  in  1  system clock
rst_n  in  1  asynchronous active-low reset
chip_d  in  DW  chip data word
chip_vld  in  1  chip_d valid; word written when chip_vld & chip_rdy
chip_rdy  out  1  buffer accepts chip words
chip_len  in  LW  frame length in words, sampled on first word of a frame
mode  in  1  0 = store-and-forward, 1 = cut-through; static while a frame is in flight
clr  in  1  synchronous flush
pcbuf_rdreq  in  1  read request
pcbuf_q  out  DW  read data
pcbuf_qvld  out  1  pcbuf_q valid, one cycle after an accepted read
pcbuf_full  out  1  complete frame held (FSM in HOLD)
pcbuf_empty  out  1  no readable word
pcbuf_usedw  out  AW+1  words stored, 0..DEPTH
ovf_err  out  1  sticky; chip word dropped

Behaviour:
- Reset (rst_n low, async): pointers = 0, usedw = 0, FSM = IDLE, chip_rdy = 1, pcbuf_qvld = 0, pcbuf_q = 0, ovf_err = 0, pcbuf_full = 0, pcbuf_empty = 1.
- Effective length: len_eff = DEPTH if chip_len == 0 or chip_len > DEPTH, else chip_len.
  - Latched into len_r on the first accepted word of a frame.
  - wr_cnt (AW+1 bits) counts accepted words of the frame.
- Write FSM:
  - IDLE: chip_rdy = 1. An accepted word latches len_r and sets wr_cnt = 1. If len_eff == 1, go to HOLD; else go to FILL.
  - FILL: chip_rdy = 1. Each accepted word increments wr_cnt. The word making wr_cnt == len_r moves the FSM to HOLD on the next cycle.
  - HOLD: chip_rdy = 0, pcbuf_full = 1. Return to IDLE on the cycle after usedw reaches 0 (FIFO fully drained).
- Drop rule: chip_vld while chip_rdy = 0 drops the word, does not write, and sets ovf_err.
  - A full FIFO is never reachable with chip_rdy = 1 because len_eff <= DEPTH.
- Readable condition:
  - mode 0: usedw != 0 and FSM == HOLD.
  - mode 1: usedw != 0.
  - pcbuf_empty = !readable.
- Read: pcbuf_rdreq & readable pops one word; pcbuf_q is registered and pcbuf_qvld = 1 in the next cycle.
  - pcbuf_rdreq while not readable is ignored: no pointer move, pcbuf_qvld = 0, no error.
  - pcbuf_q holds its last value when pcbuf_qvld = 0.
- Simultaneous write and pop: usedw unchanged. Pointers wrap modulo DEPTH.
- pcbuf_usedw is registered and reflects writes and pops of the previous edge.
- clr (synchronous, highest priority): same result as reset except pcbuf_q keeps its value; same-cycle write and read are discarded.
- chip_len and mode changes mid-frame have no effect on the frame in flight (len_r already latched).

Test Plan:
- Reset, mode 0, chip_len = 4, write 0x0001..0x0004 back-to-back:
  - chip_rdy falls the cycle after the 4th word; pcbuf_full = 1; pcbuf_empty stays 1 until HOLD, then 0; usedw = 4.
  - 4 rdreq pulses return 0x0001..0x0004, each with pcbuf_qvld one cycle later; IDLE and chip_rdy = 1 one cycle after usedw = 0.
- Mode 1, chip_len = 8, writer issues a word every other cycle while the reader requests continuously:
  - Each word is readable the cycle after it is written; usedw never exceeds 1; 8 words are delivered in order.
- chip_len = 0, AW = 4: 16 words are accepted, then HOLD; a 17th chip_vld sets ovf_err, usedw stays 16, the word is dropped.
- Simultaneous write and read in mode 1, chip_len = 3, with 1 word stored: usedw stays 1; the data order is preserved.
- Assert clr in FILL with usedw = 2 and the same-cycle chip_vld = 1 and rdreq = 1:
  - Next cycle usedw = 0, FSM = IDLE, ovf_err = 0, pcbuf_qvld = 0; the next frame is captured normally.
- Drop rst_n asynchronously mid-HOLD: all outputs take their reset values immediately, without waiting for a clock edge.
